// File: rtl/dmem_ctrl.sv
// dmem_ctrl: data-memory access controller that sits at the MEM stage.
// It turns a load/store held in the EX/MEM register into a registered
// request towards a variable-latency memory, stalls the front of the
// pipeline while the access is outstanding, and reports misaligned
// accesses and memory timeouts as one-cycle exception strobes.
module dmem_ctrl #(
  parameter int D_WIDTH = 32,
  parameter int TIMEOUT = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               mem_re_mem,
  input  logic               mem_we_mem,
  input  logic [D_WIDTH-1:0] alu_out_mem,
  input  logic [D_WIDTH-1:0] rs2_val_mem,
  input  logic               dmem_ready,
  input  logic [D_WIDTH-1:0] dmem_rdata,
  output logic               dmem_req,
  output logic               dmem_we,
  output logic [D_WIDTH-1:0] dmem_addr,
  output logic [D_WIDTH-1:0] dmem_wdata,
  output logic               stall_mem,
  output logic [D_WIDTH-1:0] load_data,
  output logic               load_valid,
  output logic               misalign_exc,
  output logic               timeout_exc
);

  // Wide enough to hold TIMEOUT itself, so the count never wraps.
  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2,
    ERR  = 2'd3
  } state_t;

  // Request as latched at launch; held untouched for the whole BUSY phase.
  typedef struct packed {
    logic               req;
    logic               we;
    logic [D_WIDTH-1:0] addr;
    logic [D_WIDTH-1:0] wdata;
  } mreq_t;

  state_t             state_q;
  mreq_t              mreq_q;
  logic [CW-1:0]      cnt_q;
  logic               is_load_q;
  logic [D_WIDTH-1:0] load_data_q;
  logic               load_valid_q;
  logic               misalign_q;
  logic               timeout_q;

  logic acc;
  logic aligned;

  assign acc     = mem_re_mem | mem_we_mem;
  assign aligned = (alu_out_mem[1:0] == 2'b00);

  // Stall is combinational so the launch cycle already freezes the
  // upstream registers; DONE/ERR release the pipeline for one cycle.
  assign stall_mem = ((state_q == IDLE) & acc & aligned) | (state_q == BUSY);

  assign dmem_req     = mreq_q.req;
  assign dmem_we      = mreq_q.we;
  assign dmem_addr    = mreq_q.addr;
  assign dmem_wdata   = mreq_q.wdata;
  assign load_data    = load_data_q;
  assign load_valid   = load_valid_q;
  assign misalign_exc = misalign_q;
  assign timeout_exc  = timeout_q;

  // Access FSM with all outputs registered; strobes default low each cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      mreq_q       <= '0;
      cnt_q        <= '0;
      is_load_q    <= 1'b0;
      load_data_q  <= '0;
      load_valid_q <= 1'b0;
      misalign_q   <= 1'b0;
      timeout_q    <= 1'b0;
    end else begin
      load_valid_q <= 1'b0;
      misalign_q   <= 1'b0;
      timeout_q    <= 1'b0;
      case (state_q)
        IDLE: begin
          if (acc) begin
            if (aligned) begin
              state_q      <= BUSY;
              mreq_q.req   <= 1'b1;
              // A simultaneous read+write request is handled as a store.
              mreq_q.we    <= mem_we_mem;
              mreq_q.addr  <= alu_out_mem;
              mreq_q.wdata <= rs2_val_mem;
              is_load_q    <= ~mem_we_mem;
              cnt_q        <= '0;
            end else begin
              misalign_q <= 1'b1;
            end
          end
        end
        BUSY: begin
          // Completion is tested first so a ready on the last allowed
          // cycle beats the timeout.
          if (dmem_ready) begin
            state_q    <= DONE;
            mreq_q.req <= 1'b0;
            if (is_load_q) begin
              load_data_q  <= dmem_rdata;
              load_valid_q <= 1'b1;
            end
          end else if (cnt_q == CNT_LAST) begin
            state_q    <= ERR;
            mreq_q.req <= 1'b0;
            timeout_q  <= 1'b1;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        // The EX/MEM register advances during DONE/ERR, so the request
        // still visible there is the finished one and must not relaunch.
        DONE:    state_q <= IDLE;
        ERR:     state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_ctrl.sv
// tb_dmem_ctrl: directed plus randomized accesses against a
// transaction-level expectation of the memory controller.
module tb_dmem_ctrl;
  localparam int DW = 32;
  localparam int TO = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          mem_re_mem, mem_we_mem;
  logic [DW-1:0] alu_out_mem, rs2_val_mem;
  logic          dmem_ready;
  logic [DW-1:0] dmem_rdata;
  logic          dmem_req, dmem_we;
  logic [DW-1:0] dmem_addr, dmem_wdata;
  logic          stall_mem;
  logic [DW-1:0] load_data;
  logic          load_valid, misalign_exc, timeout_exc;

  int nchk  = 0;
  int nfail = 0;
  logic [DW-1:0] exp_ld = '0;   // last completed load, as the model sees it

  dmem_ctrl #(.D_WIDTH(DW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .mem_re_mem(mem_re_mem), .mem_we_mem(mem_we_mem),
    .alu_out_mem(alu_out_mem), .rs2_val_mem(rs2_val_mem),
    .dmem_ready(dmem_ready), .dmem_rdata(dmem_rdata),
    .dmem_req(dmem_req), .dmem_we(dmem_we),
    .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .stall_mem(stall_mem), .load_data(load_data), .load_valid(load_valid),
    .misalign_exc(misalign_exc), .timeout_exc(timeout_exc)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One access from launch to return to IDLE. rdy_at = BUSY cycle (1-based)
  // on which memory answers; 0 or > TO means it never answers.
  task automatic access(input bit re, input bit we, input logic [DW-1:0] addr,
                        input logic [DW-1:0] wd, input int rdy_at,
                        input logic [DW-1:0] rdv);
    bit aligned;
    bit is_load;
    bit answers;
    int exp_busy;
    int stalls;
    aligned  = (addr[1:0] == 2'b00);
    is_load  = re & ~we;
    answers  = (rdy_at >= 1) && (rdy_at <= TO);
    exp_busy = answers ? rdy_at : TO;
    stalls   = 0;

    @(negedge clk);
    mem_re_mem = re; mem_we_mem = we; alu_out_mem = addr; rs2_val_mem = wd;
    dmem_ready = 1'b0;
    #1;
    chk("launch_stall", stall_mem, aligned);
    chk("launch_req", dmem_req, 0);
    if (stall_mem) stalls++;

    if (!aligned) begin
      @(negedge clk);
      mem_re_mem = 1'b0; mem_we_mem = 1'b0;
      chk("mis_exc", misalign_exc, 1);
      chk("mis_req", dmem_req, 0);
      #1 chk("mis_stall", stall_mem, 0);
      @(negedge clk);
      chk("mis_exc_clr", misalign_exc, 0);
      chk("mis_req2", dmem_req, 0);
      return;
    end

    for (int i = 1; i <= TO; i++) begin
      @(negedge clk);
      chk("busy_req", dmem_req, 1);
      chk("busy_we", dmem_we, we);
      chk("busy_addr", dmem_addr, addr);
      chk("busy_wdata", dmem_wdata, wd);
      chk("busy_lv", load_valid, 0);
      dmem_ready = (i == rdy_at);
      dmem_rdata = dmem_ready ? rdv : $urandom;
      #1;
      if (stall_mem) stalls++;
      if (dmem_ready) break;
    end

    @(negedge clk);
    // The finished request is still presented during DONE/ERR.
    if (stall_mem) stalls++;
    dmem_ready = 1'b0;
    if (answers) begin
      if (is_load) exp_ld = rdv;
      chk("done_lv", load_valid, is_load);
      chk("done_ld", load_data, exp_ld);
      chk("done_req", dmem_req, 0);
      chk("done_tmo", timeout_exc, 0);
    end else begin
      chk("err_tmo", timeout_exc, 1);
      chk("err_req", dmem_req, 0);
      chk("err_lv", load_valid, 0);
      chk("err_ld", load_data, exp_ld);
    end
    #1 chk("end_stall", stall_mem, 0);
    chk("stall_cnt", stalls, exp_busy + 1);
    mem_re_mem = 1'b0; mem_we_mem = 1'b0;

    @(negedge clk);
    chk("post_lv", load_valid, 0);
    chk("post_tmo", timeout_exc, 0);
    chk("post_req", dmem_req, 0);
    chk("post_ld", load_data, exp_ld);
  endtask

  // Idle cycles with stray memory strobes that must be ignored.
  task automatic idle_ready(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      dmem_ready = 1'b1; dmem_rdata = $urandom;
      #1;
      chk("idle_req", dmem_req, 0);
      chk("idle_lv", load_valid, 0);
      chk("idle_ld", load_data, exp_ld);
      chk("idle_stall", stall_mem, 0);
    end
    @(negedge clk);
    dmem_ready = 1'b0;
  endtask

  initial begin
    logic [DW-1:0] a;
    int kind;
    rst = 1'b1;
    mem_re_mem = 1'b0; mem_we_mem = 1'b0;
    alu_out_mem = '0; rs2_val_mem = '0;
    dmem_ready = 1'b0; dmem_rdata = '0;
    #1;
    chk("rst_req", dmem_req, 0);
    chk("rst_ld", load_data, 0);
    chk("rst_lv", load_valid, 0);
    chk("rst_stall", stall_mem, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Load, memory answers in 3rd BUSY cycle -> 4 stall cycles.
    access(1'b1, 1'b0, 32'h100, 32'h0, 3, 32'hDEADBEEF);
    // Store answered in first BUSY cycle.
    access(1'b0, 1'b1, 32'h204, 32'h12345678, 1, 32'hCAFEF00D);
    // Misaligned load.
    access(1'b1, 1'b0, 32'h102, 32'h0, 1, 32'h0);
    // No answer -> timeout after TO BUSY cycles.
    access(1'b1, 1'b0, 32'h300, 32'h0, 0, 32'h0);
    // Answer on the last allowed cycle wins.
    access(1'b1, 1'b0, 32'h304, 32'h0, TO, 32'hA5A55A5A);
    // Read+write together behaves as a store.
    access(1'b1, 1'b1, 32'h308, 32'h0BADF00D, 2, 32'h11112222);
    // Back-to-back loads.
    access(1'b1, 1'b0, 32'h400, 32'h0, 1, 32'h01020304);
    access(1'b1, 1'b0, 32'h404, 32'h0, 1, 32'h05060708);
    idle_ready(3);

    // Reset during the 2nd BUSY cycle.
    @(negedge clk);
    mem_re_mem = 1'b0; mem_we_mem = 1'b1; alu_out_mem = 32'h500; rs2_val_mem = 32'h77;
    @(negedge clk);
    @(negedge clk);
    chk("pre_rst_req", dmem_req, 1);
    rst = 1'b1; mem_we_mem = 1'b0;
    #1;
    chk("mid_rst_req", dmem_req, 0);
    chk("mid_rst_we", dmem_we, 0);
    chk("mid_rst_addr", dmem_addr, 0);
    chk("mid_rst_wdata", dmem_wdata, 0);
    chk("mid_rst_ld", load_data, 0);
    chk("mid_rst_lv", load_valid, 0);
    chk("mid_rst_exc", {misalign_exc, timeout_exc}, 0);
    chk("mid_rst_stall", stall_mem, 0);
    exp_ld = '0;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("post_rst_req", dmem_req, 0);
    end

    // Randomized accesses.
    for (int n = 0; n < 40; n++) begin
      kind = $urandom_range(0, 2);
      a = $urandom;
      if ($urandom_range(0, 5) == 0) a[1:0] = 2'($urandom_range(1, 3));
      else a[1:0] = 2'b00;
      access(kind != 1, kind != 0, a, $urandom, $urandom_range(1, TO + 2), $urandom);
      if ($urandom_range(0, 3) == 0) idle_ready(1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
    $finish;
  end

  // Hard bound in case the sequence ever stops advancing.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/dmem_ctrl.md
DMEM_CTRL -- requirements
Module: dmem_ctrl

Interface
REQ-001 The block SHALL have parameter D_WIDTH, default 32, giving the data and address width.
REQ-002 The block SHALL have parameter TIMEOUT, default 16, giving the maximum number of BUSY cycles allowed before abort (legal range 2-255).
REQ-003 The block SHALL have port clk, input, 1, the single clock; all state updates on posedge clk.
REQ-004 The block SHALL have port rst, input, 1, a reset that is asynchronous and active-high.
REQ-005 The block SHALL have port mem_re_mem, input, 1, the load request from the EX/MEM register.
REQ-006 The block SHALL have port mem_we_mem, input, 1, the store request from the EX/MEM register.
REQ-007 The block SHALL have port alu_out_mem, input, D_WIDTH, the byte address.
REQ-008 The block SHALL have port rs2_val_mem, input, D_WIDTH, the store data.
REQ-009 The block SHALL have port dmem_ready, input, 1, the memory completion strobe.
REQ-010 The block SHALL have port dmem_rdata, input, D_WIDTH, the memory read data, valid while dmem_ready=1.
REQ-011 The block SHALL have port dmem_req, output, 1, the registered memory request.
REQ-012 The block SHALL have port dmem_we, output, 1, the registered write enable.
REQ-013 The block SHALL have ports dmem_addr and dmem_wdata, output, D_WIDTH each, registered.
REQ-014 The block SHALL have port stall_mem, output, 1, combinational, which freezes the PC, IF/ID, ID/EX and EX/MEM registers.
REQ-015 The block SHALL have port load_data, output, D_WIDTH, registered, carrying the captured read data.
REQ-016 The block SHALL have port load_valid, output, 1, a one-cycle strobe.
REQ-017 The block SHALL have ports misalign_exc and timeout_exc, output, 1 each, one-cycle strobes.

Function
REQ-018 The FSM SHALL have states IDLE, BUSY, DONE and ERR; the access condition is acc = mem_re_mem | mem_we_mem.
REQ-019 In IDLE with acc=1 and alu_out_mem[1:0]=0, the block SHALL:
- go to BUSY;
- register dmem_req=1, dmem_addr=alu_out_mem, dmem_wdata=rs2_val_mem and dmem_we=mem_we_mem;
- clear the timeout counter.
REQ-020 If mem_re_mem and mem_we_mem are both 1, the access SHALL be treated as a store (dmem_we=1) and no load_valid SHALL be issued.
REQ-021 In IDLE with acc=1 and alu_out_mem[1:0]!=0, the block SHALL issue no request, register misalign_exc=1 for one cycle and stay in IDLE.
REQ-022 stall_mem SHALL be (IDLE & acc & aligned) | BUSY; it SHALL be 0 in DONE, ERR, and in IDLE when there is no access or the access is misaligned.
REQ-023 In BUSY, dmem_req, dmem_we, dmem_addr and dmem_wdata SHALL be held stable.
REQ-024 In BUSY with dmem_ready=1, the block SHALL:
- go to DONE;
- drop dmem_req;
- for a load only, capture dmem_rdata into load_data.
A dmem_ready in the first BUSY cycle is legal.
REQ-025 In BUSY with dmem_ready=0, the counter SHALL increment; when the counter equals TIMEOUT-1 and dmem_ready=0, the block SHALL go to ERR and drop dmem_req.
REQ-026 dmem_ready=1 on the final allowed cycle SHALL win over timeout.
REQ-027 DONE SHALL last exactly 1 cycle and then go to IDLE; load_valid=1 in DONE for loads only; the pipeline advances at the end of DONE.
REQ-028 ERR SHALL last exactly 1 cycle with timeout_exc=1 and then go to IDLE; load_valid=0 and load_data is unchanged.
REQ-029 dmem_ready while not in BUSY SHALL be ignored.
REQ-030 load_data SHALL hold its value until the next completed load.
REQ-031 Latency SHALL be: stall cycles = (BUSY cycles) + 1 (the IDLE launch cycle); the minimum access is 2 stall cycles plus 1 DONE cycle.
REQ-032 The counter width SHALL be $clog2(TIMEOUT+1) and the counter SHALL never wrap.

Reset
REQ-033 On rst=1, at any time including mid-BUSY, the block SHALL immediately set:
- state=IDLE;
- dmem_req=0, dmem_we=0, dmem_addr=0, dmem_wdata=0;
- load_data=0, load_valid=0, misalign_exc=0, timeout_exc=0;
- counter=0.
REQ-034 After reset release, the block SHALL start a new access only from IDLE on the next posedge with acc=1.

Verification
REQ-035 Load with addr 0x100 and dmem_ready after 3 BUSY cycles with rdata 0xDEADBEEF -> stall_mem high for 4 cycles, then load_valid=1 and load_data=0xDEADBEEF in DONE.
REQ-036 Store with addr 0x204, data 0x12345678, dmem_ready in the first BUSY cycle -> dmem_we=1, addr and data stable, stall for 2 cycles, load_valid=0.
REQ-037 Load with addr 0x102 -> misalign_exc=1 for 1 cycle, dmem_req stays 0, stall_mem=0.
REQ-038 With TIMEOUT=16 and no dmem_ready -> ERR after 16 BUSY cycles, timeout_exc=1 for 1 cycle, dmem_req=0; a second run with ready on the 16th cycle -> DONE, no timeout.
REQ-039 rst asserted in the 2nd BUSY cycle -> all outputs 0 asynchronously; after release with no access, dmem_req stays 0.
REQ-040 Back-to-back loads (second presented after DONE) -> two separate 2-cycle stall windows, each followed by a load_valid strobe.
